// File: rtl/queue_ptr_bank.sv
// queue_ptr_bank: per-task circular queue pointers with programmable windows and sticky wrap flags
module queue_ptr_bank #(
    parameter int NTASK = 2,
    parameter int TW = 1,
    parameter int PW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [TW-1:0] r_ts,
    input  logic [TW-1:0] w_ts,
    input  logic          hold,
    input  logic          ws,
    input  logic          rs,
    input  logic          q_dir,
    input  logic [PW-1:0] i_qp,
    input  logic          cfg_we,
    input  logic [TW-1:0] cfg_ts,
    input  logic [PW-1:0] cfg_base,
    input  logic [PW-1:0] cfg_limit,
    input  logic          wrap_clr,
    output logic [PW-1:0] o_qp,
    output logic          o_wrap,
    output logic          o_wrap_ev,
    output logic          o_cfg_err
);
    logic [PW-1:0] ptr [NTASK];
    logic [PW-1:0] ptr_d [NTASK];
    logic [PW-1:0] base [NTASK];
    logic [PW-1:0] limit [NTASK];
    logic [NTASK-1:0] wrap, wrap_d, wrapped, do_cfg;
    logic cfg_ok, pass;
    assign cfg_ok = cfg_we & (cfg_base <= cfg_limit);
    assign pass = ws & ~hold & (w_ts == r_ts);
    for (genvar g = 0; g < NTASK; g++) begin : g_task
        logic do_w, do_s, at_edge;
        logic [PW-1:0] nxt;
        assign do_cfg[g] = cfg_ok & (cfg_ts == TW'(g));
        assign do_w = ws & ~hold & (w_ts == TW'(g));
        assign do_s = rs & ~hold & (r_ts == TW'(g));
        assign at_edge = q_dir ? ptr[g] == base[g] : ptr[g] == limit[g];
        assign nxt = at_edge ? (q_dir ? limit[g] : base[g]) : (q_dir ? ptr[g] - PW'(1) : ptr[g] + PW'(1));
        assign wrapped[g] = do_s & ~do_w & ~do_cfg[g] & at_edge;
        assign ptr_d[g] = do_cfg[g] ? cfg_base : do_w ? i_qp : do_s ? nxt : ptr[g];
        assign wrap_d[g] = do_cfg[g] ? 1'b0 : wrapped[g] ? 1'b1 : (wrap_clr & (r_ts == TW'(g))) ? 1'b0 : wrap[g];
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NTASK; i++) begin
                ptr[i] <= '0;
                base[i] <= '0;
                limit[i] <= '1;
            end
            wrap <= '0;
            o_wrap_ev <= 1'b0;
            o_cfg_err <= 1'b0;
        end else begin
            for (int i = 0; i < NTASK; i++) begin
                ptr[i] <= ptr_d[i];
                if (do_cfg[i]) begin
                    base[i] <= cfg_base;
                    limit[i] <= cfg_limit;
                end
            end
            wrap <= wrap_d;
            o_wrap_ev <= |wrapped;
            o_cfg_err <= cfg_we & (cfg_base > cfg_limit);
        end
    end
    always_comb begin
        o_qp = '0;
        o_wrap = 1'b0;
        for (int i = 0; i < NTASK; i++) begin
            if (r_ts == TW'(i)) begin
                o_qp = pass ? i_qp : ptr[i];
                o_wrap = wrap[i];
            end
        end
    end
endmodule
